// File: rtl/challenge_poly_writer_if.sv
// challenge_poly_writer_if: coefficient input stream, z output stream and SRAM write port
interface challenge_poly_writer_if;
  logic [1:0] coeff_in;
  logic coeff_valid;
  logic coeff_ready;
  logic [15:0] A;
  logic [23:0] D;
  logic WEB;
  logic [23:0] z_out;
  logic z_valid;
  logic z_ready;
  modport master(input coeff_in, coeff_valid, z_ready, output coeff_ready, A, D, WEB, z_out, z_valid);
  modport slave(output coeff_in, coeff_valid, z_ready, input coeff_ready, A, D, WEB, z_out, z_valid);
endinterface

// File: rtl/challenge_poly_writer.sv
// challenge_poly_writer: expands a ternary challenge stream mod Q into SRAM and a z stream, checking weight
module challenge_poly_writer #(
  parameter logic [23:0] Q = 24'd8380417,
  parameter int N = 256
) (
  input logic clk,
  input logic rst_n,
  input logic start,
  input logic [1:0] ml_dsa_level,
  input logic [15:0] base_addr,
  challenge_poly_writer_if.master io,
  output logic busy,
  output logic done,
  output logic [8:0] nonzero_count,
  output logic weight_err,
  output logic enc_err
);
  localparam int IW = $clog2(N);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state;
  logic [IW-1:0] idx;
  logic [5:0] tau;
  logic [15:0] base;
  logic acc;
  logic [23:0] ev;
  assign io.coeff_ready = (state == RUN) && (!io.z_valid || io.z_ready);
  assign acc = io.coeff_valid && io.coeff_ready;
  always_comb ev = io.coeff_in == 2'b01 ? 24'd1 : io.coeff_in == 2'b11 ? Q - 24'd1 : 24'd0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      tau <= 6'd60;
      base <= '0;
      io.A <= '0;
      io.D <= '0;
      io.WEB <= 1'b1;
      io.z_out <= '0;
      io.z_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      nonzero_count <= '0;
      weight_err <= 1'b0;
      enc_err <= 1'b0;
    end else begin
      io.WEB <= !acc;
      io.z_valid <= acc || (io.z_valid && !io.z_ready);
      done <= 1'b0;
      if (acc) begin
        io.A <= base + 16'(idx);
        io.D <= ev;
        io.z_out <= ev;
        idx <= idx + 1'b1;
        nonzero_count <= nonzero_count + 9'(io.coeff_in[0]);
        enc_err <= enc_err || (io.coeff_in == 2'b10);
      end
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          base <= base_addr;
          tau <= ml_dsa_level == 2'd1 ? 6'd39 : ml_dsa_level == 2'd2 ? 6'd49 : 6'd60;
          idx <= '0;
          nonzero_count <= '0;
          enc_err <= 1'b0;
          weight_err <= 1'b0;
          busy <= 1'b1;
        end
        RUN: if (acc && idx == IW'(N - 1)) state <= DRAIN;
        DRAIN: if (io.z_valid && io.z_ready) begin
          state <= DONE;
          done <= 1'b1;
          weight_err <= nonzero_count != {3'b0, tau};
        end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
endmodule

// File: doc/challenge_poly_writer.md
Name: challenge_poly_writer

Overview:
- Downstream stage of the SampleInBall FSM.
- Consumes the challenge polynomial c as a stream of 256 ternary coefficients in index order 0..255.
- Expands each coefficient to a 24-bit value mod q (q = 8380417) and writes it to the polynomial SRAM.
- Forwards the same value on a z_out/z_valid stream with backpressure. Checks the Hamming weight against tau for the selected ML-DSA level.

Parameters:
- Q, 24'd8380417, modulus; -1 is encoded as Q-1 = 24'h7FE000
- N, 256, number of coefficients per polynomial

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; begins a polynomial transfer; ignored unless in IDLE
- ml_dsa_level  in  2  1 -> tau=39, 2 -> tau=49, other -> tau=60; sampled on start
- base_addr  in  16  SRAM base address; sampled on start
- coeff_in  in  2  ternary coefficient: 00 = 0, 01 = +1, 11 = -1, 10 = illegal
- coeff_valid  in  1  coeff_in valid
- coeff_ready  out  1  block accepts coeff_in this cycle
- A  out  16  SRAM address
- D  out  24  SRAM write data
- WEB  out  1  SRAM write enable, active-low
- z_out  out  24  expanded coefficient stream
- z_valid  out  1  z_out valid
- z_ready  in  1  downstream accepts z_out
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse after the last coefficient leaves on z
- nonzero_count  out  9  number of ±1 coefficients accepted in the current transfer
- weight_err  out  1  registered at done: nonzero_count != tau; held until next start
- enc_err  out  1  sticky: an illegal code 10 was accepted; cleared on start

Behaviour:
- Reset values (async, rst_n=0): state=IDLE, coeff_ready=0, A=0, D=0, WEB=1, z_out=0, z_valid=0, busy=0, done=0, nonzero_count=0, weight_err=0, enc_err=0, internal index=0, tau=60.
- Reset asserted mid-transfer aborts it immediately. No further SRAM writes occur. The next transfer needs a new start.
- States:
  - IDLE: start -> RUN. Latch base_addr and tau. Clear index, nonzero_count, enc_err, weight_err.
  - RUN: accept coefficients. When index==255 is accepted -> DRAIN.
  - DRAIN: wait until the last z beat is taken (z_valid && z_ready) -> DONE.
  - DONE: pulse done=1 and set weight_err for one cycle -> IDLE.
- Handshakes:
  - coeff_ready = (state==RUN) && (!z_valid || z_ready).
  - An accept happens when coeff_valid && coeff_ready.
  - z follows valid/ready rules: z_out is held stable while z_valid && !z_ready.
- Accept timing: on an accept at cycle t, at t+1:
  - z_out = D = expand(coeff_in), z_valid=1
  - A = base_addr + index (16-bit wrap-around allowed)
  - WEB=0 for exactly one cycle
  - index increments; nonzero_count increments if the code is 01 or 11
- Latency: accept to SRAM write/z_valid is 1 cycle.
- Throughput: 1 coefficient/cycle while z_ready stays high.
- On a cycle with no accept: WEB=1. A and D hold. z_valid clears when z_ready is high and no new accept occurs.
- Expansion: 00 -> 0, 01 -> 1, 11 -> 24'h7FE000. Code 10 writes 0 and sets enc_err. It does not count toward nonzero_count.
- Simultaneous z handshake and new accept in the same cycle: z_out updates to the new value with z_valid staying 1 (no bubble).
- coeff_valid in IDLE, DRAIN or DONE is ignored, with no write.
- start while busy is ignored.
- Exactly 256 writes occur per transfer, to addresses base_addr .. base_addr+255.
- The weight check compares the 9-bit nonzero_count to the 6-bit tau, zero-extended.

Test Plan:
- Level 2, base 0x0100, stream of 49 × 01 then 207 × 00, z_ready=1 → 256 writes: A 0x0100..0x01FF with WEB low each; D=1 for the first 49, 0 otherwise; done pulses 258 cycles after start; nonzero_count=49, weight_err=0.
- Level 1, 39 coefficients of 11 interleaved with zeros → D=24'h7FE000 at those indices; weight_err=0. Repeat with level 3 and the same stream → weight_err=1.
- z_ready low for 5 cycles mid-stream → coeff_ready=0 and WEB=1 during the stall; z_out held stable; no coefficient lost or duplicated; total writes=256.
- Inject code 10 at index 17 → D=0 at base+17; enc_err=1 until next start; nonzero_count excludes it.
- rst_n pulsed low at index 100 → all outputs go to their reset values immediately; no writes after; next start with base 0xFFF0 writes addresses wrapping 0xFFF0..0x00EF.
- start pulsed during RUN and coeff_valid pulsed during IDLE → both ignored; transfer count and addresses unaffected.
